// File: rtl/pipeline_pkg.sv
// Shared decode definitions for the ID stage: RV opcodes, immediate formats,
// instruction field positions and small opcode classification helpers.
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_format(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_JALR, OPC_OP_IMM, OPC_SYSTEM: return IMM_I;
            OPC_STORE:                                  return IMM_S;
            OPC_BRANCH:                                 return IMM_B;
            OPC_LUI, OPC_AUIPC:                         return IMM_U;
            OPC_JAL:                                    return IMM_J;
            default:                                    return IMM_NONE;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
               (opc == OPC_JAL)   || (opc == OPC_JALR)  || (opc == OPC_LUI)    ||
               (opc == OPC_AUIPC) || (opc == OPC_OP)    || (opc == OPC_OP_IMM) ||
               (opc == OPC_SYSTEM);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    function automatic logic uses_rd(input logic [6:0] opc);
        return !((opc == OPC_STORE) || (opc == OPC_BRANCH));
    endfunction

endpackage

// File: rtl/pipeline_imm_gen.sv
// Combinational immediate builder: classifies the opcode into an RV immediate
// format and produces the sign-extended XLEN-wide value (0 for R-type/unknown).
module pipeline_imm_gen
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_format(instr[OPC_LSB +: 7]);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = XLEN'($signed(instr[31:20]));
            IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_decode_stage.sv
// ID stage: field decode, register file with WB write-through, load-use stall
// and a valid/ready ID/EX pipeline register with flush.
module pipeline_decode_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            illegal;
    logic            advance, hazard, accept;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {27'd0, idx} < 32'(NREGS);
    endfunction

    assign opc = instr_i[OPC_LSB +: 7];
    assign f3  = instr_i[F3_LSB  +: 3];
    assign f7  = instr_i[F7_LSB  +: 7];
    assign rs1 = instr_i[RS1_LSB +: 5];
    assign rs2 = instr_i[RS2_LSB +: 5];
    assign rd  = instr_i[RD_LSB  +: 5];

    pipeline_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_i),
        .imm   (imm)
    );

    // Out-of-range indices read as zero; illegal_o flags them for EX to trap.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0 && idx_ok(rs1)) begin
            if (wb_we_i && wb_addr_i == rs1) rs1_data = wb_data_i;
            else                             rs1_data = regs[rs1[AW-1:0]];
        end
        if (rs2 != 5'd0 && idx_ok(rs2)) begin
            if (wb_we_i && wb_addr_i == rs2) rs2_data = wb_data_i;
            else                             rs2_data = regs[rs2[AW-1:0]];
        end
    end

    assign illegal = !opcode_known(opc) ||
                     (uses_rs1(opc) && !idx_ok(rs1)) ||
                     (uses_rs2(opc) && !idx_ok(rs2)) ||
                     (uses_rd(opc)  && !idx_ok(rd));

    assign advance    = out_ready_i || !out_valid_o;
    assign hazard     = ex_load_i && out_valid_o && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == rs1) || ((ex_rd_i == rs2) && uses_rs2(opc)));
    assign in_ready_o = advance && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we_i && wb_addr_i != 5'd0 && idx_ok(wb_addr_i)) begin
            regs[wb_addr_i[AW-1:0]] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            pc_o        <= '0;
            opcode_o    <= '0;
            funct3_o    <= '0;
            funct7_o    <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            imm_o       <= '0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (advance) begin
            out_valid_o <= accept;
            if (accept) begin
                pc_o       <= pc_i;
                opcode_o   <= opc;
                funct3_o   <= f3;
                funct7_o   <= f7;
                rs1_o      <= rs1;
                rs2_o      <= rs2;
                rd_o       <= rd;
                rs1_data_o <= rs1_data;
                rs2_data_o <= rs2_data;
                imm_o      <= imm;
                illegal_o  <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Bench for pipeline_decode_stage: table of decode vectors through a scoreboard,
// plus hand sequences for bypass, load-use stall, backpressure, flush and RV32E.
module tb_pipeline_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i, in_ready_o;
    logic [31:0] instr_i, pc_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_i;
    logic        flush_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        illegal_o;

    logic        d16_in_ready, d16_out_valid, d16_illegal;
    logic [31:0] d16_pc, d16_rs1_data, d16_rs2_data, d16_imm;
    logic [6:0]  d16_opcode, d16_funct7;
    logic [2:0]  d16_funct3;
    logic [4:0]  d16_rs1, d16_rs2, d16_rd;

    always #5 clk_i = ~clk_i;

    pipeline_decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .illegal_o(illegal_o)
    );

    pipeline_decode_stage #(.XLEN(32), .NREGS(16)) dut16 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(d16_in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
        .out_valid_o(d16_out_valid), .out_ready_i(out_ready_i), .pc_o(d16_pc),
        .opcode_o(d16_opcode), .funct3_o(d16_funct3), .funct7_o(d16_funct7),
        .rs1_o(d16_rs1), .rs2_o(d16_rs2), .rd_o(d16_rd), .rs1_data_o(d16_rs1_data),
        .rs2_data_o(d16_rs2_data), .imm_o(d16_imm), .illegal_o(d16_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[10];
    logic [31:0] mreg[32];
    logic [31:0] cur_imm;
    logic        cur_ill;
    logic [31:0] pc_next;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mread(input logic [4:0] i);
        if (i == 5'd0) return 32'd0;
        if (wb_we_i && wb_addr_i == i) return wb_data_i;
        return mreg[i];
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    // Scoreboard: push on input handshake, pop on output handshake, drop on flush kill.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            if (out_valid_o && out_ready_i) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", pc_o, e.pc);
                    chk("sb_opcode", {25'd0, opcode_o}, {25'd0, e.opc});
                    chk("sb_funct3", {29'd0, funct3_o}, {29'd0, e.f3});
                    chk("sb_funct7", {25'd0, funct7_o}, {25'd0, e.f7});
                    chk("sb_rd", {27'd0, rd_o}, {27'd0, e.rd});
                    chk("sb_rs1_data", rs1_data_o, e.rs1d);
                    chk("sb_rs2_data", rs2_data_o, e.rs2d);
                    chk("sb_imm", imm_o, e.imm);
                    chk("sb_illegal", {31'd0, illegal_o}, {31'd0, e.ill});
                end
            end else if (out_valid_o && flush_i && sbq.size() != 0) begin
                void'(sbq.pop_front());
            end
            if (in_valid_i && in_ready_o) begin
                e.pc   = pc_i;
                e.opc  = instr_i[6:0];
                e.f3   = instr_i[14:12];
                e.f7   = instr_i[31:25];
                e.rd   = instr_i[11:7];
                e.rs1d = mread(instr_i[19:15]);
                e.rs2d = mread(instr_i[24:20]);
                e.imm  = cur_imm;
                e.ill  = cur_ill;
                sbq.push_back(e);
            end
            if (wb_we_i && wb_addr_i != 5'd0) mreg[wb_addr_i] = wb_data_i;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] imm, input logic ill);
        in_valid_i = 1'b1;
        instr_i    = instr;
        pc_i       = pc_next;
        pc_next    = pc_next + 32'd4;
        cur_imm    = imm;
        cur_ill    = ill;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        in_valid_i = 0; instr_i = 0; pc_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
        ex_load_i = 0; ex_rd_i = 0; flush_i = 0; out_ready_i = 1;
        cur_imm = 0; cur_ill = 0; pc_next = 32'h0000_1000;

        vt[0] = '{instr: {12'hFFF, 5'd7, 3'd0, 5'd2, 7'h13},        imm: 32'hFFFF_FFFF, ill: 1'b0};
        vt[1] = '{instr: 32'hFE00_0EE3,                             imm: 32'hFFFF_FFFC, ill: 1'b0};
        vt[2] = '{instr: 32'h0010_00EF,                             imm: 32'h0000_0800, ill: 1'b0};
        vt[3] = '{instr: 32'hABCD_E1B7,                             imm: 32'hABCD_E000, ill: 1'b0};
        vt[4] = '{instr: {7'h7F, 5'd5, 5'd1, 3'd2, 5'h18, 7'h23},   imm: 32'hFFFF_FFF8, ill: 1'b0};
        vt[5] = '{instr: {7'h00, 5'd5, 5'd7, 3'd0, 5'd8, 7'h33},    imm: 32'h0000_0000, ill: 1'b0};
        vt[6] = '{instr: {25'h0, 7'h7F},                            imm: 32'h0000_0000, ill: 1'b1};
        vt[7] = '{instr: {20'h80000, 5'd4, 7'h17},                  imm: 32'h8000_0000, ill: 1'b0};
        vt[8] = '{instr: {12'h7FF, 5'd5, 3'd2, 5'd6, 7'h03},        imm: 32'h0000_07FF, ill: 1'b0};
        vt[9] = '{instr: {7'h20, 5'd7, 5'd5, 3'd0, 5'd9, 7'h33},    imm: 32'h0000_0000, ill: 1'b0};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_rs1_data", rs1_data_o, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        rst_i = 1'b0;
        cyc();

        // WB write then read one cycle later
        wb_we_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'h0000_1234;
        cyc();
        wb_we_i = 0;
        drive(enc_r(5'd1, 5'd5, 5'd0), 32'd0, 1'b0);
        cyc();
        idle();
        chk("t1_out_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t1_rs1_data", rs1_data_o, 32'h0000_1234);

        // Same-cycle write-through bypass
        wb_we_i = 1; wb_addr_i = 5'd7; wb_data_i = 32'h0000_CAFE;
        drive({12'hFFF, 5'd7, 3'd0, 5'd2, 7'h13}, 32'hFFFF_FFFF, 1'b0);
        cyc();
        wb_we_i = 0;
        idle();
        chk("t2_rs1_bypass", rs1_data_o, 32'h0000_CAFE);
        chk("t2_imm", imm_o, 32'hFFFF_FFFF);

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].instr, vt[i].imm, vt[i].ill);
            cyc();
        end
        idle();
        cyc();

        // Load-use: one bubble, then the held instruction issues
        drive({12'h000, 5'd0, 3'd2, 5'd3, 7'h03}, 32'd0, 1'b0);
        cyc();
        drive(enc_r(5'd4, 5'd3, 5'd3), 32'd0, 1'b0);
        ex_load_i = 1; ex_rd_i = 5'd3;
        #1;
        chk("t3_ready_stall", {31'd0, in_ready_o}, 32'd0);
        cyc();
        chk("t3_bubble", {31'd0, out_valid_o}, 32'd0);
        chk("t3_ready_reissue", {31'd0, in_ready_o}, 32'd1);
        cyc();
        ex_load_i = 0;
        idle();
        chk("t3_issue_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t3_issue_rd", {27'd0, rd_o}, 32'd4);

        // Flush coinciding with hazard: no extra stall cycle
        drive({12'h000, 5'd0, 3'd2, 5'd3, 7'h03}, 32'd0, 1'b0);
        cyc();
        drive(enc_r(5'd4, 5'd3, 5'd3), 32'd0, 1'b0);
        ex_load_i = 1; ex_rd_i = 5'd3; flush_i = 1;
        #1;
        chk("fh_ready", {31'd0, in_ready_o}, 32'd0);
        cyc();
        flush_i = 0;
        #1;
        chk("fh_valid", {31'd0, out_valid_o}, 32'd0);
        chk("fh_ready_next", {31'd0, in_ready_o}, 32'd1);
        cyc();
        ex_load_i = 0;
        idle();
        chk("fh_issue", {31'd0, out_valid_o}, 32'd1);

        // Backpressure for 3 cycles, then flush during the stall
        drive({12'd5, 5'd0, 3'd0, 5'd9, 7'h13}, 32'd5, 1'b0);
        cyc();
        out_ready_i = 0;
        drive({12'd6, 5'd0, 3'd0, 5'd10, 7'h13}, 32'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_ready", {31'd0, in_ready_o}, 32'd0);
            chk("t5_valid", {31'd0, out_valid_o}, 32'd1);
            chk("t5_imm_hold", imm_o, 32'd5);
            chk("t5_rd_hold", {27'd0, rd_o}, 32'd9);
            cyc();
        end
        flush_i = 1;
        cyc();
        flush_i = 0;
        out_ready_i = 1;
        chk("t5_flush_valid", {31'd0, out_valid_o}, 32'd0);
        cyc();
        idle();
        chk("t5_after_valid", {31'd0, out_valid_o}, 32'd1);
        chk("t5_after_imm", imm_o, 32'd6);

        // RV32E: indices >= 16 are illegal, x0/x17 writes have no effect
        drive(enc_r(5'd20, 5'd1, 5'd2), 32'd0, 1'b0);
        cyc();
        idle();
        chk("t6_ill16", {31'd0, d16_illegal}, 32'd1);
        chk("t6_ill32", {31'd0, illegal_o}, 32'd0);
        wb_we_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'h0000_DEAD;
        cyc();
        wb_addr_i = 5'd17; wb_data_i = 32'h0000_BEEF;
        cyc();
        wb_we_i = 0;
        drive(enc_r(5'd5, 5'd0, 5'd17), 32'd0, 1'b0);
        cyc();
        drive(enc_r(5'd6, 5'd1, 5'd0), 32'd0, 1'b0);
        chk("t6_x0_32", rs1_data_o, 32'd0);
        chk("t6_x0_16", d16_rs1_data, 32'd0);
        chk("t6_x17_32", rs2_data_o, 32'h0000_BEEF);
        chk("t6_x17_16", d16_rs2_data, 32'd0);
        chk("t6_x17_ill16", {31'd0, d16_illegal}, 32'd1);
        cyc();
        idle();
        chk("t6_x1_nowrap", d16_rs1_data, 32'd0);
        chk("t6_x1_legal16", {31'd0, d16_illegal}, 32'd0);

        repeat (3) cyc();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
